// File: rtl/ram_rd_seg.sv
// -----------------------------------------------------------------------------
// ram_rd_seg
//
// Six-digit multiplexed seven-segment display for a RAM read monitor. The
// right-hand three digits show rd_data in decimal and the left-hand three
// digits show addr in decimal. A decimal point on digit 3 separates the two
// groups.
//
// A small converter FSM watches the {addr, rd_data} pair. When the pair
// changes, it latches the new pair and runs an 8-step double-dabble on both
// bytes in parallel. It then copies the BCD results into the display
// registers. A free-running scan counter steps through the digits.
//
// Ports
//   sys_clk    in   1  rising-edge clock
//   sys_rst_n  in   1  asynchronous active-low reset
//   rd_en      in   1  read phase active; segments are blanked while low
//   addr       in   8  current RAM address
//   rd_data    in   8  RAM read data for addr
//   sel        out  6  digit select, active-low one-hot, sel[0] = rightmost
//   seg        out  8  segments {dp,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module ram_rd_seg #(
    parameter logic [15:0] CNT_SCAN_MAX = 16'd49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rd_en,
    input  logic [7:0] addr,
    input  logic [7:0] rd_data,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Converter state
    state_t      state_q, state_d;
    logic [7:0]  cap_addr_q, cap_addr_d;
    logic [7:0]  cap_data_q, cap_data_d;
    // Double-dabble working registers: {hundreds, tens, units, binary}
    logic [19:0] sh_addr_q, sh_addr_d;
    logic [19:0] sh_data_q, sh_data_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] disp_addr_q, disp_addr_d;
    logic [11:0] disp_data_q, disp_data_d;

    // Scan / output state
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]  dig_idx_q, dig_idx_d;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;

    // Digit selection helpers
    logic [3:0]  nib;
    logic        blank;
    logic        dp_on;
    logic [7:0]  code;

    // One double-dabble step. Each BCD nibble that is 5 or more gets 3
    // added before the shift, so it carries correctly into the next decade.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    // Common-anode decode with the dp segment off. Values outside 0..9
    // cannot occur after a conversion and decode to blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Converter FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cap_addr_d  = cap_addr_q;
        cap_data_d  = cap_data_q;
        sh_addr_d   = sh_addr_q;
        sh_data_d   = sh_data_q;
        bit_cnt_d   = bit_cnt_q;
        disp_addr_d = disp_addr_q;
        disp_data_d = disp_data_q;

        case (state_q)
            IDLE: begin
                // Inputs are only compared here. A change that arrives during
                // SHIFT or DONE is picked up on the first IDLE cycle afterwards.
                if ({addr, rd_data} != {cap_addr_q, cap_data_q}) begin
                    cap_addr_d = addr;
                    cap_data_d = rd_data;
                    sh_addr_d  = {12'd0, addr};
                    sh_data_d  = {12'd0, rd_data};
                    bit_cnt_d  = 3'd0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                sh_addr_d = dd_step(sh_addr_q);
                sh_data_d = dd_step(sh_data_q);
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_addr_d = sh_addr_q[19:8];
                disp_data_d = sh_data_q[19:8];
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Scan counter and digit index
    // -------------------------------------------------------------------------
    always_comb begin
        scan_cnt_d = scan_cnt_q + 16'd1;
        dig_idx_d  = dig_idx_q;
        if (scan_cnt_q == CNT_SCAN_MAX) begin
            scan_cnt_d = 16'd0;
            dig_idx_d  = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Digit content: value, leading-zero blanking, decimal point
    // -------------------------------------------------------------------------
    always_comb begin
        nib   = 4'd0;
        blank = 1'b0;
        dp_on = 1'b0;
        case (dig_idx_q)
            3'd0: nib = disp_data_q[3:0];
            3'd1: begin
                nib   = disp_data_q[7:4];
                blank = (disp_data_q[11:8] == 4'd0) && (disp_data_q[7:4] == 4'd0);
            end
            3'd2: begin
                nib   = disp_data_q[11:8];
                blank = (disp_data_q[11:8] == 4'd0);
            end
            3'd3: begin
                nib   = disp_addr_q[3:0];
                dp_on = 1'b1;
            end
            3'd4: begin
                nib   = disp_addr_q[7:4];
                blank = (disp_addr_q[11:8] == 4'd0) && (disp_addr_q[7:4] == 4'd0);
            end
            3'd5: begin
                nib   = disp_addr_q[11:8];
                blank = (disp_addr_q[11:8] == 4'd0);
            end
            default: blank = 1'b1;
        endcase

        code = blank ? 8'hFF : seg_decode(nib);
        // The decimal point stays lit on digit 3 even when the digit is blank.
        if (dp_on) begin
            code[7] = 1'b0;
        end

        // sel and seg both follow the registered index. As a result they
        // change together, one clock after the index moves.
        sel_d = ~(6'd1 << dig_idx_q);
        seg_d = rd_en ? code : 8'hFF;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cap_addr_q  <= 8'd0;
            cap_data_q  <= 8'd0;
            sh_addr_q   <= 20'd0;
            sh_data_q   <= 20'd0;
            bit_cnt_q   <= 3'd0;
            disp_addr_q <= 12'd0;
            disp_data_q <= 12'd0;
            scan_cnt_q  <= 16'd0;
            dig_idx_q   <= 3'd0;
            sel_q       <= 6'b111111;
            seg_q       <= 8'hFF;
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            sh_addr_q   <= sh_addr_d;
            sh_data_q   <= sh_data_d;
            bit_cnt_q   <= bit_cnt_d;
            disp_addr_q <= disp_addr_d;
            disp_data_q <= disp_data_d;
            scan_cnt_q  <= scan_cnt_d;
            dig_idx_q   <= dig_idx_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_ram_rd_seg.sv
module tb_ram_rd_seg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_en;
    logic [7:0] addr;
    logic [7:0] rd_data;
    logic [5:0] sel;
    logic [7:0] seg;

    always #5 clk = ~clk;

    ram_rd_seg #(.CNT_SCAN_MAX(16'd3)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .rd_en     (rd_en),
        .addr      (addr),
        .rd_data   (rd_data),
        .sel       (sel),
        .seg       (seg)
    );

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   hold_chk = 1'b0;

    // Expected segment codes, {digit5, ..., digit0}
    localparam logic [47:0] T_ZERO = {8'hFF, 8'hFF, 8'h40, 8'hFF, 8'hFF, 8'hC0}; // 0. / 0
    localparam logic [47:0] T_7255 = {8'hFF, 8'hFF, 8'h78, 8'hA4, 8'h92, 8'h92}; // 7. / 255
    localparam logic [47:0] T_8100 = {8'hFF, 8'hFF, 8'h00, 8'hF9, 8'hC0, 8'hC0}; // 8. / 100
    localparam logic [47:0] T_1289 = {8'hF9, 8'hA4, 8'h00, 8'hFF, 8'hFF, 8'h90}; // 128. / 9

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected entry on every digit change
    logic [5:0] mon_prev = 6'h3F;
    int         mon_run  = 0;
    exp_t       mon_e;
    initial begin
        forever begin
            @(negedge clk);
            mon_run++;
            if (sel !== mon_prev) begin
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    check("scan_sel", {26'd0, sel}, {26'd0, mon_e.sel});
                    check("scan_seg", {24'd0, seg}, {24'd0, mon_e.seg});
                end
                if (hold_chk) begin
                    check("hold_len", mon_run, 4);
                    check("one_low", $countones(~sel), 1);
                end
                mon_run  = 0;
                mon_prev = sel;
            end
        end
    end

    // Queue one full scan (digit0..digit5) starting at the next digit0
    task automatic check_scan(input string name, input logic [47:0] codes);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sel === 6'b011111) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check({name, "_sync"}, 0, 1);
            return;
        end
        #1;
        for (int d = 0; d < 6; d++) begin
            exp_t e;
            e.sel = ~(6'd1 << d);
            e.seg = codes[8*d +: 8];
            q.push_back(e);
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check({name, "_drain"}, q.size(), 0);
            q.delete();
        end
    endtask

    // Clocks from the input change until the display registers hold 'want'
    task automatic meas(input logic [23:0] want, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if ({dut.disp_addr_q, dut.disp_data_q} === want) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic int dig_of(input logic [5:0] s);
        int d;
        d = -1;
        for (int k = 0; k < 6; k++) begin
            if (s[k] === 1'b0) d = k;
        end
        return d;
    endfunction

    initial begin
        int   lat;
        int   t1;
        int   t2;
        int   bad;
        int   trans;
        int   d;
        logic [5:0] ps;
        logic [7:0] want;

        rst_n   = 1'b0;
        rd_en   = 1'b1;
        addr    = 8'd0;
        rd_data = 8'd0;

        // Reset held: outputs at reset values and stable
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_sel", {26'd0, sel}, 32'h3F);
            check("rst_seg", {24'd0, seg}, 32'hFF);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero display
        check_scan("zero", T_ZERO);

        // addr 7, data 255: latency and digits
        @(negedge clk);
        addr    = 8'd7;
        rd_data = 8'd255;
        meas(24'h007_255, lat);
        check("lat_7_255", lat, 10);
        check_scan("s7_255", T_7255);

        // addr 8 / data 255, data changed to 100 during SHIFT
        @(negedge clk);
        addr = 8'd8;
        t1 = 0;
        t2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) rd_data = 8'd100;
            if (t1 == 0 && {dut.disp_addr_q, dut.disp_data_q} === 24'h008_255) t1 = i;
            if ({dut.disp_addr_q, dut.disp_data_q} === 24'h008_100) begin
                t2 = i;
                break;
            end
        end
        check("lat_first", t1, 10);
        check("lat_second", t2 - t1, 10);
        check_scan("s8_100", T_8100);

        // rd_en low for 20 clocks
        @(negedge clk);
        rd_en = 1'b0;
        bad   = 0;
        trans = 0;
        ps    = sel;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (seg !== 8'hFF) bad++;
            if (sel !== ps) trans++;
            ps = sel;
        end
        check("rden_off_seg", bad, 0);
        check("rden_off_scan", (trans >= 4) ? 1 : 0, 1);
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        d = dig_of(sel);
        want = (d >= 0) ? T_8100[8*d +: 8] : 8'h00;
        check("rden_back_seg", {24'd0, seg}, {24'd0, want});

        // Reset during SHIFT, then convert 128 / 9 from scratch
        @(negedge clk);
        addr    = 8'd128;
        rd_data = 8'd9;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_sel", {26'd0, sel}, 32'h3F);
        check("async_seg", {24'd0, seg}, 32'hFF);
        check("async_disp", {8'd0, dut.disp_addr_q, dut.disp_data_q}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_sel", {26'd0, sel}, 32'h3F);
            check("hold_seg", {24'd0, seg}, 32'hFF);
        end
        rst_n = 1'b1;
        meas(24'h128_009, lat);
        check("lat_128_9", lat, 10);
        check_scan("s128_9", T_1289);

        // Twelve full scan cycles with hold-length checking
        hold_chk = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check_scan("scan12", T_1289);
        end
        hold_chk = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
